// File: rtl/bit_serial_lu_seq_pkg.sv
// Shared constants for the bit-serial logic unit: word width, opcode encodings,
// FSM state codes and the latched-operand record.
package bit_serial_lu_seq_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  localparam logic [2:0] OP_NOT_A = 3'b000;
  localparam logic [2:0] OP_AND   = 3'b001;
  localparam logic [2:0] OP_NAND  = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_NOR   = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_XNOR  = 3'b110;
  localparam logic [2:0] OP_ZERO  = 3'b111;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
    logic             neg_b;
  } operands_t;

endpackage

// File: rtl/bit_serial_lu_seq_if.sv
// Request/response bundle between a requester (master) and the bit-serial
// logic unit (slave).
interface bit_serial_lu_seq_if;
  import bit_serial_lu_seq_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic             neg_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] bit_idx;

  modport master (
    output start, a, b, sel, neg_b,
    input  busy, done, result, bit_idx
  );

  modport slave (
    input  start, a, b, sel, neg_b,
    output busy, done, result, bit_idx
  );
endinterface

// File: rtl/bit_serial_lu_seq_lu_bit_cell.sv
// One-bit logic cell: applies the selected operation to a single bit of A and
// the (optionally inverted) matching bit of B.
module lu_bit_cell
  import bit_serial_lu_seq_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [2:0] sel,
  input  logic       neg_b,
  output logic       y
);

  logic bb;

  always_comb begin
    bb = b ^ neg_b;
    y  = 1'b0;
    case (sel)
      OP_NOT_A: y = ~a;
      OP_AND:   y = a & bb;
      OP_NAND:  y = ~(a & bb);
      OP_OR:    y = a | bb;
      OP_NOR:   y = ~(a | bb);
      OP_XOR:   y = a ^ bb;
      OP_XNOR:  y = ~(a ^ bb);
      OP_ZERO:  y = 1'b0;
      default:  y = 1'b0;
    endcase
  end

endmodule

// File: rtl/bit_serial_lu_seq.sv
// Bit-serial logic unit: latches an operand pair, evaluates one bit per clock
// LSB first through a single lu_bit_cell, then publishes the whole word at once.
module bit_serial_lu_seq
  import bit_serial_lu_seq_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  bit_serial_lu_seq_if.slave  bus
);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  operands_t        ops_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] result_reg;
  logic             done_reg;
  logic             bit_y;
  logic             last_bit;

  lu_bit_cell u_cell (
    .a     (ops_reg.a[cnt_reg]),
    .b     (ops_reg.b[cnt_reg]),
    .sel   (ops_reg.sel),
    .neg_b (ops_reg.neg_b),
    .y     (bit_y)
  );

  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      ops_reg    <= '0;
      shift_reg  <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            ops_reg   <= '{a: bus.a, b: bus.b, sel: bus.sel, neg_b: bus.neg_b};
            cnt_reg   <= '0;
            shift_reg <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          shift_reg[cnt_reg] <= bit_y;
          if (last_bit) begin
            // The final bit bypasses shift_reg so result updates in one step.
            result_reg <= {bit_y, shift_reg[WIDTH-2:0]};
            done_reg   <= 1'b1;
            cnt_reg    <= '0;
            state_reg  <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = (state_reg == RUN) || (state_reg == DONE);
  assign bus.done    = done_reg;
  assign bus.result  = result_reg;
  assign bus.bit_idx = (state_reg == RUN) ? cnt_reg : '0;

endmodule

// File: tb/tb_bit_serial_lu_seq.sv
// Scoreboard bench for bit_serial_lu_seq: directed operand pairs push their
// hand-computed result and expected done cycle; a monitor checks each done.
module tb_bit_serial_lu_seq;
  import bit_serial_lu_seq_pkg::*;

  typedef struct {
    logic [7:0] res;
    int         cyc;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic [7:0] last_result = 8'h00;

  bit_serial_lu_seq_if bus();

  bit_serial_lu_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end else begin
      $display("check %s: %0h (cycle %0d)", name, got, cyc);
    end
  endtask

  // Monitor: every done pops one expectation; between completions result must hold.
  always @(negedge clk) begin
    if (reset) begin
      last_result = 8'h00;
    end else if (bus.done) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got result %0h with no pending operation (cycle %0d)",
                 bus.result, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.result !== e.res || cyc != e.cyc) begin
          errors++;
          $display("FAIL %s: got result %0h at cycle %0d expected %0h at cycle %0d",
                   e.name, bus.result, cyc, e.res, e.cyc);
        end else begin
          $display("done %s: result %0h at cycle %0d", e.name, bus.result, cyc);
        end
        last_result = e.res;
      end
    end else begin
      checks++;
      if (bus.result !== last_result) begin
        errors++;
        $display("FAIL result_hold: got %0h expected %0h (cycle %0d)", bus.result, last_result, cyc);
      end
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                       input logic neg);
    bus.a = a; bus.b = b; bus.sel = sel; bus.neg_b = neg;
  endtask

  // Starts one operation from IDLE; returns at the negedge after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                       input logic neg, input logic [7:0] exp, input string name, input bit push);
    @(negedge clk);
    drive(a, b, sel, neg);
    bus.start = 1'b1;
    if (push) q.push_back('{exp, cyc + 9, name});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending, busy=%0b expected 0 pending and idle",
               name, q.size(), bus.busy);
    end
  endtask

  initial begin
    int busy_cnt;
    bus.start = 1'b0;
    drive(8'h00, 8'h00, 3'b000, 1'b0);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", 32'(bus.result), 32'h00);
    check("reset_bit_idx", 32'(bus.bit_idx), 32'd0);

    // AND with bit-by-bit index and busy-length tracking
    issue(8'hA5, 8'h0F, OP_AND, 1'b0, 8'h05, "and_a5_0f", 1'b1);
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("bit_idx_%0d", k), 32'(bus.bit_idx), 32'(k));
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
    check("done_state_bit_idx", 32'(bus.bit_idx), 32'd0);
    if (bus.busy) busy_cnt++;
    @(negedge clk);
    if (bus.busy) busy_cnt++;
    check("busy_cycles", 32'(busy_cnt), 32'd9);
    check("idle_after_done", 32'(bus.busy), 32'd0);
    drain("and");

    issue(8'hA5, 8'h0F, OP_XOR,   1'b1, 8'h55, "xor_negb",  1'b1); drain("xor");
    issue(8'hA5, 8'h0F, OP_NOT_A, 1'b0, 8'h5A, "not_a",     1'b1); drain("not");
    issue(8'hA5, 8'h0F, OP_ZERO,  1'b0, 8'h00, "zero",      1'b1); drain("zero");
    issue(8'hA5, 8'h0F, OP_NAND,  1'b0, 8'hFA, "nand",      1'b1); drain("nand");
    issue(8'hA5, 8'h0F, OP_XNOR,  1'b0, 8'h55, "xnor",      1'b1); drain("xnor");
    issue(8'h3C, 8'hF0, OP_AND,   1'b1, 8'h0C, "and_negb",  1'b1); drain("and_negb");
    issue(8'h00, 8'h00, OP_NOR,   1'b0, 8'hFF, "nor_zero",  1'b1); drain("nor");

    // Start and operand changes during RUN must not disturb the running op
    issue(8'hA5, 8'h0F, OP_AND, 1'b0, 8'h05, "busy_start", 1'b1);
    repeat (3) @(negedge clk);
    drive(8'hFF, 8'hFF, OP_OR, 1'b1);
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    drain("busy_start");

    // Reset in the middle of RUN discards the operation
    issue(8'hA5, 8'h0F, OP_ZERO, 1'b0, 8'h00, "pre_reset_zero", 1'b1); drain("pre_reset");
    issue(8'hA5, 8'h0F, OP_NOR, 1'b0, 8'h00, "aborted", 1'b0);
    repeat (4) @(negedge clk);
    check("abort_bit_idx", 32'(bus.bit_idx), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", 32'(bus.result), 32'h00);
    check("abort_bit_idx_zero", 32'(bus.bit_idx), 32'd0);
    repeat (12) @(negedge clk);
    issue(8'hA5, 8'h0F, OP_AND, 1'b0, 8'h05, "after_reset", 1'b1); drain("after_reset");

    // Back-to-back with start held: one completion every 10 cycles
    @(negedge clk);
    drive(8'hA5, 8'h0F, OP_OR, 1'b0);
    bus.start = 1'b1;
    q.push_back('{8'hAF, cyc + 9, "b2b_or"});
    @(negedge clk);
    drive(8'h3C, 8'hF0, OP_AND, 1'b1);
    q.push_back('{8'h0C, cyc + 18, "b2b_and"});
    repeat (10) @(negedge clk);
    drive(8'hA5, 8'h0F, OP_XNOR, 1'b0);
    q.push_back('{8'h55, cyc + 18, "b2b_xnor"});
    repeat (10) @(negedge clk);
    bus.start = 1'b0;
    drain("b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected end of test before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bit_serial_lu_seq.md
BIT_SERIAL_LU_SEQ -- requirements
Module: bit_serial_lu_seq

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to process one operand pair; sampled only in IDLE.
REQ-005 a  input  8  operand A, captured on an accepted start.
REQ-006 b  input  8  operand B, captured on an accepted start.
REQ-007 sel  input  3  operation code, captured on an accepted start.
REQ-008 neg_b  input  1  inverts B before the operation, captured on an accepted start.
REQ-009 busy  output  1  high while in RUN or DONE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 result  output  8  last completed result, held until the next completion.
REQ-012 bit_idx  output  3  index of the bit being processed in RUN, 0 otherwise.

Function
REQ-013 SHALL implement the states IDLE, RUN and DONE.
REQ-014 IDLE with start=1 at edge E0 SHALL latch a, b, sel and neg_b, clear the counter and enter RUN.
REQ-015 In RUN, each edge SHALL compute one bit, LSB first: cnt 0..7, with the bit written to the internal shift register position cnt.
REQ-016 Per-bit operation, with bb = b[i] XOR neg_b:
- 000: NOT a[i]
- 001: a AND bb
- 010: NAND
- 011: OR
- 100: NOR
- 101: XOR
- 110: XNOR
- 111: constant 0
REQ-017 At the edge with cnt==7 (E8), result SHALL load the complete 8-bit word and the state SHALL go to DONE.
REQ-018 done SHALL be high exactly in the cycle after E8; the next edge (E9) SHALL return the state to IDLE.
REQ-019 Latency SHALL be exactly 8 cycles from the edge that samples start to done high, and start SHALL next be accepted at E9.
REQ-020 start while busy SHALL be ignored, with no latch, no queueing and no effect on the in-progress operation.
REQ-021 a, b, sel and neg_b changing during RUN SHALL NOT affect the result, because operands are latched.
REQ-022 result SHALL NOT change except at a completing edge or at reset, and partial bits SHALL never be visible on result.
REQ-023 bit_idx SHALL equal cnt during RUN and 0 in IDLE and DONE.

Reset
REQ-024 While reset is high at a rising edge: state=IDLE, cnt=0, busy=0, done=0, result=8'h00, bit_idx=0, latched operands=0.
REQ-025 Reset SHALL take priority over start and over any in-progress operation.
REQ-026 Reset mid-RUN SHALL discard partial bits without producing a done pulse.
REQ-027 The first start accepted after reset deasserts SHALL behave exactly as in REQ-014 to REQ-019.

Structure
REQ-028 A shared package SHALL hold:
- the width constant (8);
- the 3-bit sel encodings (OP_NOT_A, OP_AND, OP_NAND, OP_OR, OP_NOR, OP_XOR, OP_XNOR, OP_ZERO);
- the state enumeration (IDLE, RUN, DONE).
REQ-029 The per-bit function SHALL be a combinational sub-module, lu_bit_cell, with inputs a, b, sel and neg_b and output y.
REQ-030 The top level SHALL instantiate lu_bit_cell exactly once, with no combinational path from inputs to outputs.

Verification
REQ-031 reset, then start with a=A5, b=0F, sel=001, neg_b=0 -> done 8 cycles later with result=05, busy high for 9 cycles.
REQ-032 a=A5, b=0F, sel=101, neg_b=1 -> result=55.
REQ-033 Opcode sweep:
- a=A5, sel=000 -> result=5A.
- sel=111 -> result=00.
- a=00, b=00, sel=100 -> result=FF.
REQ-034 start again during RUN with different operands -> ignored; the original result is produced and exactly one done pulse occurs.
REQ-035 reset asserted at bit_idx=4 -> no done, result stays at its previous value of 00, busy=0 next cycle; a new start then completes normally.
REQ-036 Back-to-back: start held high continuously -> operations complete with done every 10 cycles, result updated each time.
